// File: rtl/threadbrain_pkg.sv
`default_nettype none
// ============================================================================
// Package : threadbrain_pkg
// Brief   : Shared types and constants for the thread-core spawn/fork path.
// Rev     : 1.0  initial release
// ============================================================================
package threadbrain_pkg;

    localparam int         ADDR_W_DEFAULT = 16;
    // Must stay in sync with the fork stage decoder.
    localparam logic [3:0] FORK_OPCODE    = 4'h7;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        PENDING = 2'd1,
        RUNNING = 2'd2
    } core_state_e;

    typedef enum logic [0:0] {
        L_IDLE  = 1'b0,
        L_OFFER = 1'b1
    } launch_fsm_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick; search starts one past i_last_id.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import threadbrain_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_last_id,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_id,
    output logic           o_grant_vld
);

    logic [IDW-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_id  = '0;
        o_grant_vld = 1'b0;
        w_idx       = '0;
        // Offsets 1..N visit every requester once, the last grantee last.
        for (int k = 1; k <= N; k++) begin
            w_idx = IDW'((int'(i_last_id) + k) % N);
            if (!o_grant_vld && i_req[w_idx]) begin
                o_grant_vld    = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : core_spawn_ctrl
// Brief  : Per-core OFF/PENDING/RUNNING lifecycle, serialised launch handshake
//          and halt tracking. Optional stats enabled by CORE_SPAWN_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module core_spawn_ctrl
    import threadbrain_pkg::*;
#(
    parameter int                NCORES  = 4,
    parameter int                ADDR_W  = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] BOOT_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCORES-1:0]             core_ens_nxt,
    input  logic [NCORES*ADDR_W-1:0]      core_starts_nxt,
    input  logic [NCORES-1:0]             core_halt,
    output logic [NCORES-1:0]             core_ens,
    output logic [NCORES*ADDR_W-1:0]      core_starts,
    output logic                          launch_valid,
    input  logic                          launch_ready,
    output logic [$clog2(NCORES)-1:0]     launch_id,
    output logic [ADDR_W-1:0]             launch_pc,
    output logic                          all_halted,
    output logic [15:0]                   launch_count,
    output logic [$clog2(NCORES+1)-1:0]   peak_active
);

    localparam int ID_W  = $clog2(NCORES);
    localparam int CNT_W = $clog2(NCORES + 1);

    core_state_e                r_state     [NCORES];
    core_state_e                w_state_nxt [NCORES];
    logic [NCORES*ADDR_W-1:0]   r_starts;
    logic [NCORES*ADDR_W-1:0]   w_starts_nxt;

    launch_fsm_e                r_fsm;
    launch_fsm_e                w_fsm_nxt;
    logic                       r_valid;
    logic                       w_valid_nxt;
    logic [ID_W-1:0]            r_id;
    logic [ID_W-1:0]            w_id_nxt;
    logic [ID_W-1:0]            r_last_id;
    logic [ID_W-1:0]            w_last_id_nxt;
    logic [ADDR_W-1:0]          r_pc;
    logic [ADDR_W-1:0]          w_pc_nxt;
    logic                       r_all_halted;

    logic [NCORES-1:0]          w_pending;
    logic [NCORES-1:0]          w_grant;
    logic [ID_W-1:0]            w_grant_id;
    logic                       w_grant_vld;
    logic [ADDR_W-1:0]          w_pick_pc;
    logic                       w_accept;
    logic                       w_all_off;

    genvar gi;
    generate
        for (gi = 0; gi < NCORES; gi++) begin : g_core
            assign w_pending[gi] = (r_state[gi] == PENDING);
            assign core_ens[gi]  = (r_state[gi] != OFF);
        end
    endgenerate

    assign w_all_off = ~|core_ens;
    assign w_accept  = (r_fsm == L_OFFER) && launch_ready;

    rr_arbiter #(
        .N   (NCORES),
        .IDW (ID_W)
    ) u_arb (
        .i_req       (w_pending),
        .i_last_id   (r_last_id),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_grant_vld (w_grant_vld)
    );

    always_comb begin
        w_pick_pc = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_grant[i]) begin
                w_pick_pc = w_pick_pc | r_starts[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Per-core lifecycle; requests that do not match the current state are dropped.
    always_comb begin
        w_starts_nxt = r_starts;
        for (int i = 0; i < NCORES; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                OFF: begin
                    if (core_ens_nxt[i]) begin
                        w_state_nxt[i] = PENDING;
                        w_starts_nxt[i*ADDR_W +: ADDR_W] = core_starts_nxt[i*ADDR_W +: ADDR_W];
                    end
                end
                PENDING: begin
                    if (w_accept && (int'(r_id) == i)) begin
                        w_state_nxt[i] = RUNNING;
                    end
                end
                RUNNING: begin
                    if (core_halt[i]) begin
                        w_state_nxt[i] = OFF;
                    end
                end
                default: w_state_nxt[i] = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCORES; i++) begin
                r_state[i] <= (i == 0) ? RUNNING : OFF;
            end
            r_starts <= {{((NCORES-1)*ADDR_W){1'b0}}, BOOT_PC};
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            r_starts <= w_starts_nxt;
        end
    end

    // Launch FSM: IDLE always takes one cycle, giving the mandatory bubble.
    always_comb begin
        w_fsm_nxt     = r_fsm;
        w_valid_nxt   = r_valid;
        w_id_nxt      = r_id;
        w_pc_nxt      = r_pc;
        w_last_id_nxt = r_last_id;
        case (r_fsm)
            L_IDLE: begin
                if (w_grant_vld) begin
                    w_fsm_nxt   = L_OFFER;
                    w_valid_nxt = 1'b1;
                    w_id_nxt    = w_grant_id;
                    w_pc_nxt    = w_pick_pc;
                end
            end
            L_OFFER: begin
                if (launch_ready) begin
                    w_fsm_nxt     = L_IDLE;
                    w_valid_nxt   = 1'b0;
                    w_last_id_nxt = r_id;
                end
            end
            default: begin
                w_fsm_nxt   = L_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= L_IDLE;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_pc      <= '0;
            r_last_id <= '0;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_valid   <= w_valid_nxt;
            r_id      <= w_id_nxt;
            r_pc      <= w_pc_nxt;
            r_last_id <= w_last_id_nxt;
        end
    end

    // Sticky until reset, even if the fork stage later re-enables a core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_all_halted <= 1'b0;
        end else if (w_all_off && (r_fsm == L_IDLE)) begin
            r_all_halted <= 1'b1;
        end
    end

    assign core_starts  = r_starts;
    assign launch_valid = r_valid;
    assign launch_id    = r_id;
    assign launch_pc    = r_pc;
    assign all_halted   = r_all_halted;

`ifdef CORE_SPAWN_STATS_EN
    logic [15:0]      r_launch_count;
    logic [CNT_W-1:0] r_peak;
    logic [CNT_W-1:0] w_active;

    always_comb begin
        w_active = '0;
        for (int i = 0; i < NCORES; i++) begin
            w_active = w_active + CNT_W'(core_ens[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_launch_count <= '0;
            r_peak         <= '0;
        end else begin
            if (w_accept && (r_launch_count != 16'hFFFF)) begin
                r_launch_count <= r_launch_count + 16'd1;
            end
            if (w_active > r_peak) begin
                r_peak <= w_active;
            end
        end
    end

    assign launch_count = r_launch_count;
    assign peak_active  = r_peak;
`else
    assign launch_count = '0;
    assign peak_active  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_core_spawn_ctrl
// Brief  : Scenario-task bench for core_spawn_ctrl with a launch scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_core_spawn_ctrl;

    localparam logic [15:0] BOOT = 16'hB000;
`ifdef CORE_SPAWN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] pc;
    } launch_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  core_ens_nxt = '0;
    logic [63:0] core_starts_nxt = '0;
    logic [3:0]  core_halt = '0;
    logic [3:0]  core_ens;
    logic [63:0] core_starts;
    logic        launch_valid;
    logic        launch_ready = 1'b0;
    logic [1:0]  launch_id;
    logic [15:0] launch_pc;
    logic        all_halted;
    logic [15:0] launch_count;
    logic [2:0]  peak_active;

    int n_cmp = 0;
    int n_bad = 0;
    launch_t q[$];

    core_spawn_ctrl #(
        .NCORES  (4),
        .ADDR_W  (16),
        .BOOT_PC (BOOT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_ens_nxt    (core_ens_nxt),
        .core_starts_nxt (core_starts_nxt),
        .core_halt       (core_halt),
        .core_ens        (core_ens),
        .core_starts     (core_starts),
        .launch_valid    (launch_valid),
        .launch_ready    (launch_ready),
        .launch_id       (launch_id),
        .launch_pc       (launch_pc),
        .all_halted      (all_halted),
        .launch_count    (launch_count),
        .peak_active     (peak_active)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every accepted launch must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && launch_valid && launch_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL launch_unexpected: got id=%0d pc=%h, required no launch", launch_id, launch_pc);
            end else begin
                launch_t e;
                e = q.pop_front();
                if (launch_id !== e.id || launch_pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL launch_pop: got id=%0d pc=%h, required id=%0d pc=%h",
                             launch_id, launch_pc, e.id, e.pc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        core_ens_nxt = '0; core_halt = '0; core_starts_nxt = '0; launch_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b0001) begin
            n_bad++; $display("FAIL reset_ens: got %b, required 0001", core_ens);
        end
        n_cmp++;
        if (core_starts !== {48'h0, BOOT}) begin
            n_bad++; $display("FAIL reset_starts: got %h, required %h", core_starts, {48'h0, BOOT});
        end
        n_cmp++;
        if (launch_valid !== 1'b0 || launch_id !== 2'd0 || launch_pc !== 16'h0) begin
            n_bad++; $display("FAIL reset_launch: got v=%b id=%0d pc=%h, required 0/0/0", launch_valid, launch_id, launch_pc);
        end
        n_cmp++;
        if (all_halted !== 1'b0) begin
            n_bad++; $display("FAIL reset_halted: got %b, required 0", all_halted);
        end
        n_cmp++;
        if (launch_count !== 16'd0 || peak_active !== 3'd0) begin
            n_bad++; $display("FAIL reset_stats: got cnt=%0d peak=%0d, required 0/0", launch_count, peak_active);
        end
    endtask

    task automatic test_spawn_one;
        tick;
        core_ens_nxt = 4'b0011;
        core_starts_nxt[16 +: 16] = 16'h0123;
        launch_ready = 1'b1;
        q.push_back(launch_t'{id: 2'd1, pc: 16'h0123});
        tick;
        core_ens_nxt = '0;
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b0011 || core_starts[16 +: 16] !== 16'h0123 || launch_valid !== 1'b0) begin
            n_bad++; $display("FAIL spawn_pending: got ens=%b s1=%h v=%b, required 0011/0123/0", core_ens, core_starts[16 +: 16], launch_valid);
        end
        tick;
        @(negedge clk);
        n_cmp++;
        if (launch_valid !== 1'b1 || launch_id !== 2'd1 || launch_pc !== 16'h0123) begin
            n_bad++; $display("FAIL spawn_offer: got v=%b id=%0d pc=%h, required 1/1/0123", launch_valid, launch_id, launch_pc);
        end
        tick;
        @(negedge clk);
        n_cmp++;
        if (launch_valid !== 1'b0 || core_ens !== 4'b0011) begin
            n_bad++; $display("FAIL spawn_accept: got v=%b ens=%b, required 0/0011", launch_valid, core_ens);
        end
    endtask

    task automatic test_backpressure;
        tick;
        launch_ready = 1'b0;
        core_ens_nxt = 4'b1100;
        core_starts_nxt[32 +: 16] = 16'h0222;
        core_starts_nxt[48 +: 16] = 16'h0333;
        q.push_back(launch_t'{id: 2'd2, pc: 16'h0222});
        q.push_back(launch_t'{id: 2'd3, pc: 16'h0333});
        tick;
        core_ens_nxt = '0;
        tick;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (launch_valid !== 1'b1 || launch_id !== 2'd2 || launch_pc !== 16'h0222) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got v=%b id=%0d pc=%h, required 1/2/0222", c, launch_valid, launch_id, launch_pc);
            end
            tick;
        end
        launch_ready = 1'b1;
        tick;
        @(negedge clk);
        n_cmp++;
        if (launch_valid !== 1'b0 || core_ens !== 4'b1111) begin
            n_bad++; $display("FAIL bubble: got v=%b ens=%b, required 0/1111", launch_valid, core_ens);
        end
        tick;
        @(negedge clk);
        n_cmp++;
        if (launch_valid !== 1'b1 || launch_id !== 2'd3 || launch_pc !== 16'h0333) begin
            n_bad++; $display("FAIL second_offer: got v=%b id=%0d pc=%h, required 1/3/0333", launch_valid, launch_id, launch_pc);
        end
        tick;
        @(negedge clk);
        n_cmp++;
        if (launch_valid !== 1'b0 || q.size() != 0) begin
            n_bad++; $display("FAIL bp_drain: got v=%b pending=%0d, required 0/0", launch_valid, q.size());
        end
    endtask

    task automatic test_halt;
        tick;
        launch_ready = 1'b0;
        core_halt = 4'b1110;
        tick;
        core_halt = '0;
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b0001 || all_halted !== 1'b0) begin
            n_bad++; $display("FAIL halt_three: got ens=%b h=%b, required 0001/0", core_ens, all_halted);
        end
        tick;
        core_halt = 4'b0001;
        tick;
        core_halt = '0;
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b0000) begin
            n_bad++; $display("FAIL halt_last: got ens=%b, required 0000", core_ens);
        end
        tick;
        @(negedge clk);
        n_cmp++;
        if (all_halted !== 1'b1) begin
            n_bad++; $display("FAIL all_halted: got %b, required 1", all_halted);
        end
        tick;
        core_halt = 4'b1111;
        tick;
        core_halt = '0;
        tick;
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b0000 || all_halted !== 1'b1 || launch_valid !== 1'b0) begin
            n_bad++; $display("FAIL halt_noop: got ens=%b h=%b v=%b, required 0000/1/0", core_ens, all_halted, launch_valid);
        end
    endtask

    task automatic test_async_reset;
        tick;
        core_ens_nxt = 4'b0010;
        core_starts_nxt[16 +: 16] = 16'h0BAD;
        launch_ready = 1'b0;
        q.push_back(launch_t'{id: 2'd1, pc: 16'h0BAD});
        tick;
        core_ens_nxt = '0;
        tick;
        @(negedge clk);
        n_cmp++;
        if (launch_valid !== 1'b1 || launch_pc !== 16'h0BAD) begin
            n_bad++; $display("FAIL async_pre: got v=%b pc=%h, required 1/0BAD", launch_valid, launch_pc);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (launch_valid !== 1'b0 || launch_id !== 2'd0 || launch_pc !== 16'h0) begin
            n_bad++; $display("FAIL async_launch: got v=%b id=%0d pc=%h, required 0/0/0", launch_valid, launch_id, launch_pc);
        end
        n_cmp++;
        if (core_ens !== 4'b0001 || core_starts !== {48'h0, BOOT}) begin
            n_bad++; $display("FAIL async_state: got ens=%b starts=%h, required 0001/%h", core_ens, core_starts, {48'h0, BOOT});
        end
        n_cmp++;
        if (all_halted !== 1'b0) begin
            n_bad++; $display("FAIL async_halted: got %b, required 0", all_halted);
        end
        q.delete();
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_stats;
        tick;
        launch_ready = 1'b1;
        core_ens_nxt = 4'b0110;
        core_starts_nxt[16 +: 16] = 16'h1111;
        core_starts_nxt[32 +: 16] = 16'h2222;
        q.push_back(launch_t'{id: 2'd1, pc: 16'h1111});
        q.push_back(launch_t'{id: 2'd2, pc: 16'h2222});
        tick;
        core_ens_nxt = '0;
        for (int k = 0; k < 20 && q.size() != 0; k++) tick;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL stats_launch_timeout: got %0d outstanding, required 0", q.size());
        end
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b0111) begin
            n_bad++; $display("FAIL stats_running: got %b, required 0111", core_ens);
        end
        tick;
        core_halt = 4'b0100;
        core_ens_nxt = 4'b1000;
        core_starts_nxt[48 +: 16] = 16'h3333;
        q.push_back(launch_t'{id: 2'd3, pc: 16'h3333});
        tick;
        core_halt = '0;
        core_ens_nxt = '0;
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b1011) begin
            n_bad++; $display("FAIL halt_and_spawn: got %b, required 1011", core_ens);
        end
        tick;
        for (int k = 0; k < 20 && q.size() != 0; k++) tick;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++; $display("FAIL stats_third_timeout: got %0d outstanding, required 0", q.size());
        end
        tick;
        tick;
        @(negedge clk);
        n_cmp++;
        if (core_ens !== 4'b1011) begin
            n_bad++; $display("FAIL stats_final_ens: got %b, required 1011", core_ens);
        end
        n_cmp++;
        if (launch_count !== (STATS ? 16'd3 : 16'd0)) begin
            n_bad++; $display("FAIL launch_count: got %0d, required %0d", launch_count, STATS ? 3 : 0);
        end
        n_cmp++;
        if (peak_active !== (STATS ? 3'd3 : 3'd0)) begin
            n_bad++; $display("FAIL peak_active: got %0d, required %0d", peak_active, STATS ? 3 : 0);
        end
    endtask

    initial begin
        test_reset;
        test_spawn_one;
        test_backpressure;
        test_halt;
        test_async_reset;
        test_stats;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
